ring_osc_meter: RTL and testbench

//  Clock-domain measurement controller directly downstream of the gated ring-oscillator counter.

---
 rtl/ring_osc_pkg.sv | 20 ++
 rtl/ring_osc_meter_bus_sync2.sv | 26 ++
 rtl/ring_osc_meter.sv | 192 +++++++++++++++++++
 tb/tb_ring_osc_meter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_osc_pkg.sv
// Shared types and constants for the gated ring-oscillator measurement path.
package ring_osc_pkg;

  localparam int unsigned RING_COUNT_W = 15;

  typedef enum logic [2:0] {
    IDLE,
    GATE,
    SETTLE,
    SAMPLE,
    NEXT,
    DONE
  } ring_osc_state_e;

  // Bits needed for a counter that runs 0 .. max_val-1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/ring_osc_meter_bus_sync2.sv
// Two-flop per-bit synchronizer for a bus that is held static while sampled.
module bus_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ring_osc_meter.sv
// Gate-window controller for the ring-oscillator counter: gates, settles,
// samples the held count and averages 2^AVG_LOG2 runs into one result.
module ring_osc_meter
  import ring_osc_pkg::*;
#(
  parameter int unsigned COUNT_W       = RING_COUNT_W,
  parameter int unsigned GATE_W        = 16,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STABLE_TMO    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [GATE_W-1:0]  gate_len,
  output logic               osc_en,
  input  logic [COUNT_W-1:0] count_in,
  output logic [COUNT_W-1:0] result,
  output logic               result_valid,
  output logic               busy,
  output logic               saturated,
  output logic               unstable
);

  localparam int unsigned ACC_W   = COUNT_W + AVG_LOG2;
  localparam int unsigned RUN_W   = AVG_LOG2 + 1;
  localparam int unsigned TMR_MAX = (SETTLE_CYCLES > STABLE_TMO) ? SETTLE_CYCLES : STABLE_TMO;
  localparam int unsigned TMR_W   = cnt_width(TMR_MAX);

  localparam logic [RUN_W-1:0] LAST_RUN    = RUN_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(STABLE_TMO - 1);

  ring_osc_state_e    state_q, state_d;
  logic [GATE_W-1:0]  glen_q, glen_d;
  logic [GATE_W-1:0]  gcnt_q, gcnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] samp_q, samp_d;
  logic               satf_q, satf_d;
  logic               unsf_q, unsf_d;
  logic [COUNT_W-1:0] result_q, result_d;
  logic               sat_q, sat_d;
  logic               uns_q, uns_d;
  logic               osc_en_q;
  logic               valid_q;
  logic               busy_q;

  logic [COUNT_W-1:0] sync_cnt;
  logic [GATE_W-1:0]  glen_in;
  logic               capture;

  bus_sync2 #(
    .WIDTH (COUNT_W)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (count_in),
    .q_o   (sync_cnt)
  );

  // Gate counter holds G-1 so a zero length still yields a one-cycle window.
  assign glen_in = (gate_len == '0) ? '0 : gate_len - GATE_W'(1);

  always_comb begin
    state_d  = state_q;
    glen_d   = glen_q;
    gcnt_d   = gcnt_q;
    tmr_d    = tmr_q;
    run_d    = run_q;
    acc_d    = acc_q;
    samp_d   = samp_q;
    satf_d   = satf_q;
    unsf_d   = unsf_q;
    result_d = result_q;
    sat_d    = sat_q;
    uns_d    = uns_q;
    capture  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GATE;
          glen_d  = glen_in;
          gcnt_d  = glen_in;
        end
      end
      GATE: begin
        if (gcnt_q == '0) begin
          state_d = SETTLE;
          tmr_d   = '0;
        end else begin
          gcnt_d = gcnt_q - GATE_W'(1);
        end
      end
      SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      SAMPLE: begin
        // First SAMPLE cycle only primes the reference sample.
        samp_d = sync_cnt;
        if ((tmr_q != '0) && (sync_cnt == samp_q)) begin
          capture = 1'b1;
        end else if (tmr_q == TMO_LAST) begin
          capture = 1'b1;
          unsf_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
        if (capture) begin
          state_d = NEXT;
          acc_d   = acc_q + ACC_W'(sync_cnt);
          if (sync_cnt == '1) begin
            satf_d = 1'b1;
          end
        end
      end
      NEXT: begin
        if (run_q == LAST_RUN) begin
          state_d  = DONE;
          result_d = acc_q[AVG_LOG2 +: COUNT_W];
          sat_d    = satf_q;
          uns_d    = unsf_q;
        end else begin
          state_d = GATE;
          run_d   = run_q + RUN_W'(1);
          gcnt_d  = glen_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        acc_d   = '0;
        run_d   = '0;
        satf_d  = 1'b0;
        unsf_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      glen_q   <= '0;
      gcnt_q   <= '0;
      tmr_q    <= '0;
      run_q    <= '0;
      acc_q    <= '0;
      samp_q   <= '0;
      satf_q   <= 1'b0;
      unsf_q   <= 1'b0;
      result_q <= '0;
      sat_q    <= 1'b0;
      uns_q    <= 1'b0;
      osc_en_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      glen_q   <= glen_d;
      gcnt_q   <= gcnt_d;
      tmr_q    <= tmr_d;
      run_q    <= run_d;
      acc_q    <= acc_d;
      samp_q   <= samp_d;
      satf_q   <= satf_d;
      unsf_q   <= unsf_d;
      result_q <= result_d;
      sat_q    <= sat_d;
      uns_q    <= uns_d;
      osc_en_q <= (state_d == GATE);
      valid_q  <= (state_d == DONE);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign osc_en       = osc_en_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign saturated    = sat_q;
  assign unstable     = uns_q;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Directed bench: one meter with single-run averaging, one with four-run averaging,
// each driven by a behavioural ring-counter model.
module tb_ring_osc_meter;

  localparam int unsigned S   = 4;
  localparam int unsigned TMO = 8;
  localparam int unsigned NV  = 10;

  logic        clk;
  logic        rst_n;
  logic [1:0]  start_v;
  logic [15:0] glen_v [2];
  logic [14:0] cin_v  [2];
  logic [14:0] res_v  [2];
  logic [1:0]  osc_v, val_v, busy_v, sat_v, uns_v;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  ring_osc_meter #(.COUNT_W(15), .GATE_W(16), .AVG_LOG2(0), .SETTLE_CYCLES(S), .STABLE_TMO(TMO)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .gate_len(glen_v[0]), .osc_en(osc_v[0]),
    .count_in(cin_v[0]), .result(res_v[0]), .result_valid(val_v[0]), .busy(busy_v[0]),
    .saturated(sat_v[0]), .unstable(uns_v[0]));

  ring_osc_meter #(.COUNT_W(15), .GATE_W(16), .AVG_LOG2(2), .SETTLE_CYCLES(S), .STABLE_TMO(TMO)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .gate_len(glen_v[1]), .osc_en(osc_v[1]),
    .count_in(cin_v[1]), .result(res_v[1]), .result_valid(val_v[1]), .busy(busy_v[1]),
    .saturated(sat_v[1]), .unstable(uns_v[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ring model: rate in thousandths of a count per clk, cleared on enable rise,
  // saturating at all-ones, held while disabled (optionally with bit0 toggling).
  int unsigned rate [2][4];
  int unsigned cur_rate [2];
  int unsigned macc [2];
  int unsigned m_run [2];
  bit          m_prev [2];
  bit          tog_en [2];
  bit          tog [2];
  int unsigned p_cnt [2], hi [2], gap [2], min_len [2], max_len [2], min_gap [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int unsigned c;
      if (osc_v[i] === 1'b1) begin
        if (!m_prev[i]) begin
          cur_rate[i] = rate[i][m_run[i] & 3];
          m_run[i]++;
          macc[i] = cur_rate[i];
          tog[i] = 1'b0;
          if (p_cnt[i] != 0 && gap[i] < min_gap[i]) min_gap[i] = gap[i];
          p_cnt[i]++;
          hi[i] = 0;
        end else begin
          macc[i] += cur_rate[i];
        end
        hi[i]++;
      end else begin
        if (tog_en[i]) tog[i] = ~tog[i];
        if (m_prev[i]) begin
          if (hi[i] < min_len[i]) min_len[i] = hi[i];
          if (hi[i] > max_len[i]) max_len[i] = hi[i];
          gap[i] = 0;
        end
        gap[i]++;
      end
      c = macc[i] / 1000;
      if (c > 32767) c = 32767;
      cin_v[i] = 15'(c) ^ {14'd0, tog[i]};
      m_prev[i] = (osc_v[i] === 1'b1);
    end
  end

  typedef struct {
    int unsigned dut;
    int unsigned glen;
    int unsigned r0, r1, r2, r3;
    bit          tg;
    int unsigned lo, hi;
    bit          sat, uns;
    int unsigned lat, runs, len;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int unsigned got, input int unsigned lo,
                         input int unsigned hi_v);
    n_vec++;
    if (got < lo || got > hi_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi_v);
    end
  endtask

  task automatic mon_clear(input int d);
    p_cnt[d] = 0; hi[d] = 0; gap[d] = 0;
    min_len[d] = 32'hFFFF_FFFF; max_len[d] = 0; min_gap[d] = 32'hFFFF_FFFF;
    m_run[d] = 0;
  endtask

  // Returns edges counted after the current point until result_valid is seen.
  task automatic wait_valid(input int d, output int unsigned n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (val_v[d]) seen = 1'b1;
    end
  endtask

  // Latency reported in cycles, counting the accept cycle as the first.
  task automatic do_meas(input int d, input int unsigned g, output int unsigned lat,
                         output bit b0, output bit seen);
    int unsigned n;
    glen_v[d] = 16'(g);
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    b0 = busy_v[d];
    wait_valid(d, n, seen);
    lat = n + 2;
  endtask

  initial begin
    int unsigned lat, seen_cnt, osc_cnt, busy_cnt, n;
    bit b0, seen;
    int d;

    vecs[0] = '{1, 50, 2960, 3000, 3040, 3080, 0, 151, 151, 0, 0, 230, 4, 50};
    vecs[1] = '{1, 50, 1000, 1000000, 1000, 1000, 0, 8229, 8229, 1, 0, 230, 4, 50};
    vecs[2] = '{1, 20, 3000, 3000, 3000, 3000, 1, 60, 61, 0, 1, 134, 4, 20};
    vecs[3] = '{1, 0, 5000, 5000, 5000, 5000, 0, 5, 5, 0, 0, 34, 4, 1};
    vecs[4] = '{0, 100, 3000, 3000, 3000, 3000, 0, 300, 300, 0, 0, 109, 1, 100};
    vecs[5] = '{0, 0, 7000, 7000, 7000, 7000, 0, 7, 7, 0, 0, 10, 1, 1};
    vecs[6] = '{0, 1, 7000, 7000, 7000, 7000, 0, 7, 7, 0, 0, 10, 1, 1};
    vecs[7] = '{0, 3, 4500, 4500, 4500, 4500, 0, 13, 13, 0, 0, 12, 1, 3};
    vecs[8] = '{0, 40, 1000000, 1000000, 1000000, 1000000, 0, 32767, 32767, 1, 0, 49, 1, 40};
    vecs[9] = '{0, 5, 2000, 2000, 2000, 2000, 1, 10, 11, 0, 1, 20, 1, 5};

    for (int i = 0; i < 2; i++) begin
      cin_v[i] = '0; glen_v[i] = '0; macc[i] = 0; m_prev[i] = 0; tog_en[i] = 0; tog[i] = 0;
      cur_rate[i] = 0;
      for (int j = 0; j < 4; j++) rate[i][j] = 0;
      mon_clear(i);
    end
    start_v = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: nothing moves for 100 cycles.
    seen_cnt = 0; osc_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (val_v != 2'b00) seen_cnt++;
      if (osc_v != 2'b00) osc_cnt++;
      if (busy_v != 2'b00) busy_cnt++;
    end
    chk("idle valid cycles", seen_cnt, 0);
    chk("idle osc_en cycles", osc_cnt, 0);
    chk("idle busy cycles", busy_cnt, 0);
    chk("reset result u0", int'(res_v[0]), 0);
    chk("reset result u2", int'(res_v[1]), 0);
    chk("reset flags", {28'd0, sat_v, uns_v}, 0);

    for (int v = 0; v < int'(NV); v++) begin
      d = int'(vecs[v].dut);
      rate[d][0] = vecs[v].r0; rate[d][1] = vecs[v].r1;
      rate[d][2] = vecs[v].r2; rate[d][3] = vecs[v].r3;
      tog_en[d] = vecs[v].tg;
      mon_clear(d);
      do_meas(d, vecs[v].glen, lat, b0, seen);
      chk($sformatf("v%0d valid seen", v), seen, 1);
      chk($sformatf("v%0d busy after accept", v), b0, 1);
      chk_rng($sformatf("v%0d result", v), int'(res_v[d]), vecs[v].lo, vecs[v].hi);
      chk($sformatf("v%0d saturated", v), sat_v[d], vecs[v].sat);
      chk($sformatf("v%0d unstable", v), uns_v[d], vecs[v].uns);
      chk($sformatf("v%0d latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d osc pulses", v), p_cnt[d], vecs[v].runs);
      chk($sformatf("v%0d min pulse len", v), min_len[d], vecs[v].len);
      chk($sformatf("v%0d max pulse len", v), max_len[d], vecs[v].len);
      if (vecs[v].runs > 1)
        chk($sformatf("v%0d gap >= settle+3", v), (min_gap[d] >= S + 3) ? 1 : 0, 1);
      @(posedge clk); #1;
      chk($sformatf("v%0d valid one cycle", v), val_v[d], 0);
      chk($sformatf("v%0d busy drops", v), busy_v[d], 0);
      chk($sformatf("v%0d result held", v), (int'(res_v[d]) >= vecs[v].lo &&
          int'(res_v[d]) <= vecs[v].hi) ? 1 : 0, 1);
      tog_en[d] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end

    // Reset during the gate window, 20 cycles in.
    for (int j = 0; j < 4; j++) rate[0][j] = 3000;
    mon_clear(0);
    glen_v[0] = 16'd100;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("midrst osc_en before", osc_v[0], 1);
    rst_n = 1'b0;
    #1;
    chk("midrst osc_en drops", osc_v[0], 0);
    chk("midrst busy drops", busy_v[0], 0);
    chk("midrst result cleared", int'(res_v[0]), 0);
    chk("midrst flags cleared", {30'd0, sat_v[0], uns_v[0]}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen_cnt = 0;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      if (val_v[0]) seen_cnt++;
    end
    chk("midrst no valid", seen_cnt, 0);
    mon_clear(0);
    do_meas(0, 100, lat, b0, seen);
    chk("postrst valid seen", seen, 1);
    chk("postrst result", int'(res_v[0]), 300);
    chk("postrst latency", lat, 109);
    repeat (3) @(posedge clk);
    #1;

    // start held through DONE; gate_len change mid-run only affects the next accept.
    for (int j = 0; j < 4; j++) rate[0][j] = 2000;
    mon_clear(0);
    glen_v[0] = 16'd10;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    glen_v[0] = 16'd50;
    wait_valid(0, n, seen);
    chk("b2b first valid", seen, 1);
    chk("b2b first latency", n + 2, 19);
    chk("b2b first result", int'(res_v[0]), 20);
    @(posedge clk); #1;
    chk("b2b idle gap busy", busy_v[0], 0);
    chk("b2b idle gap valid", val_v[0], 0);
    @(posedge clk); #1;
    chk("b2b restart busy", busy_v[0], 1);
    chk("b2b restart osc_en", osc_v[0], 1);
    start_v[0] = 1'b0;
    glen_v[0] = 16'd7;
    wait_valid(0, n, seen);
    chk("b2b second valid", seen, 1);
    chk("b2b second result", int'(res_v[0]), 100);
    chk("b2b pulses", p_cnt[0], 2);
    chk("b2b first gate len", min_len[0], 10);
    chk("b2b second gate len", max_len[0], 50);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
